// File: rtl/aes128_cipher_if.sv
// Start/result bundle for aes128_cipher: key and block in with a valid/ready start handshake,
// result block and round status out.
interface aes128_cipher_if;
  logic [127:0] s_aes_key;
  logic [127:0] s_aes_block;
  logic         s_aes_valid;
  logic         s_aes_ready;
  logic [127:0] m_aes_block;
  logic [3:0]   round;
  logic [127:0] round_key;

  modport master (
    output s_aes_key, s_aes_block, s_aes_valid,
    input  s_aes_ready, m_aes_block, round, round_key
  );

  modport slave (
    input  s_aes_key, s_aes_block, s_aes_valid,
    output s_aes_ready, m_aes_block, round, round_key
  );
endinterface

// File: rtl/aes128_cipher.sv
// Iterative AES-128 core, one direction per instance, round keys computed on the fly.
// CFG_MODE trades S-box count for cycles per round; results are identical in every mode.
module aes128_cipher #(
  parameter string CFG_DIR  = "ENC",
  parameter string CFG_MODE = "DEFAULT"
) (
  input logic            clk,
  input logic            rst,
  aes128_cipher_if.slave aes
);

  localparam bit IsDec  = (CFG_DIR == "DEC");
  localparam bit IsFast = (CFG_MODE == "FAST");
  localparam bit IsTiny = (CFG_MODE == "TINY");

  // Slot schedule inside one round: substitution steps, key step, and the finishing step.
  localparam logic [2:0] SubSteps = IsTiny ? 3'd4 : 3'd1;
  localparam logic [2:0] KeyStep  = IsTiny ? 3'd4 : 3'd0;
  localparam logic [2:0] LastStep = IsFast ? 3'd0 : (IsTiny ? 3'd5 : 3'd1);

  typedef enum logic [1:0] {StIdle, StInit, StRound, StDone} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] out_q, out_d;
  logic [3:0]   round_q, round_d;
  logic [2:0]   step_q, step_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Forward and inverse S-box share the field inverse; only the affine step moves.
  function automatic logic [7:0] sbox_any(input logic [7:0] x, input bit inv);
    logic [7:0] t;
    logic [7:0] y;
    t = inv ? ({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05) : x;
    y = gf_inv(t);
    if (!inv) begin
      y = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    end
    return y;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((inv ? c - r + 4 : c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    o       = '0;
    coef[0] = inv ? 8'h0e : 8'h02;
    coef[1] = inv ? 8'h0b : 8'h03;
    coef[2] = inv ? 8'h0d : 8'h01;
    coef[3] = inv ? 8'h09 : 8'h01;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gf_mul(coef[(j - r + 4) % 4], a[j]);
        o[127-8*(4*c+r) -: 8] = b;
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Forward step yields K(r+1) from K(r); inverse step yields K(r-1) from K(r).
  // sw is SubWord(RotWord()) of w3 (forward) or of the recovered w3 (inverse).
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [31:0] sw,
                                            input logic [7:0] rc, input bit inv);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = sw ^ {rc, 24'h000000};
    if (!inv) begin
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
    end else begin
      w3 = w3 ^ w2;
      w2 = w2 ^ w1;
      w1 = w1 ^ w0;
      w0 = w0 ^ t;
    end
    return {w0, w1, w2, w3};
  endfunction

  logic [31:0]  key_w3;
  logic [31:0]  key_rot;
  logic [127:0] sub_state;
  logic [31:0]  key_sw;
  logic [127:0] key_nx;
  logic [127:0] fin_in;
  logic [127:0] fin_key;
  logic [127:0] fin_state;
  logic [3:0]   round_nx;
  logic         last_round;

  assign key_w3  = IsDec ? (key_q[31:0] ^ key_q[63:32]) : key_q[31:0];
  assign key_rot = {key_w3[23:0], key_w3[31:24]};

  if (IsTiny) begin : g_tiny
    logic        key_sel;
    logic [1:0]  col;
    logic [31:0] sin;
    logic [31:0] sout;

    assign key_sel = (step_q == KeyStep);
    assign col     = step_q[1:0];

    // Four S-boxes walk the state columns, then serve the key word.
    always_comb begin
      sin  = key_sel ? key_rot : state_q[127-32*int'(col) -: 32];
      sout = '0;
      for (int i = 0; i < 4; i++) begin
        sout[31-8*i -: 8] = sbox_any(sin[31-8*i -: 8], IsDec && !key_sel);
      end
      sub_state = state_q;
      sub_state[127-32*int'(col) -: 32] = sout;
      key_sw = sout;
    end
  end else begin : g_wide
    always_comb begin
      sub_state = '0;
      key_sw    = '0;
      for (int i = 0; i < 16; i++) begin
        sub_state[127-8*i -: 8] = sbox_any(state_q[127-8*i -: 8], IsDec);
      end
      for (int i = 0; i < 4; i++) begin
        key_sw[31-8*i -: 8] = sbox_any(key_rot[31-8*i -: 8], 1'b0);
      end
    end
  end

  assign round_nx   = IsDec ? (round_q - 4'd1) : (round_q + 4'd1);
  assign last_round = IsDec ? (round_q == 4'd1) : (round_q == 4'd9);
  assign key_nx     = key_step(key_q, key_sw, rcon(IsDec ? round_q : round_q + 4'd1), IsDec);
  assign fin_in     = IsFast ? sub_state : state_q;
  assign fin_key    = IsFast ? key_nx : key_q;

  always_comb begin
    fin_state = '0;
    if (!IsDec) begin
      fin_state = last_round ? (shift_rows(fin_in, 1'b0) ^ fin_key)
                             : (mix_cols(shift_rows(fin_in, 1'b0), 1'b0) ^ fin_key);
    end else begin
      fin_state = shift_rows(fin_in, 1'b1) ^ fin_key;
      if (!last_round) fin_state = mix_cols(fin_state, 1'b1);
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    out_d   = out_q;
    round_d = round_q;
    step_d  = step_q;
    unique case (fsm_q)
      StIdle: begin
        if (aes.s_aes_valid) begin
          state_d = aes.s_aes_block;
          key_d   = aes.s_aes_key;
          fsm_d   = StInit;
        end
      end
      StInit: begin
        state_d = state_q ^ key_q;
        round_d = IsDec ? 4'd10 : 4'd0;
        step_d  = '0;
        fsm_d   = StRound;
      end
      StRound: begin
        if (!IsFast && (step_q < SubSteps)) state_d = sub_state;
        if (!IsFast && (step_q == KeyStep)) key_d = key_nx;
        if (step_q == LastStep) begin
          state_d = fin_state;
          if (IsFast) key_d = key_nx;
          round_d = round_nx;
          step_d  = '0;
          if (last_round) fsm_d = StDone;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      StDone: begin
        out_d = state_q;
        fsm_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      key_q   <= '0;
      out_q   <= '0;
      round_q <= '0;
      step_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      out_q   <= out_d;
      round_q <= round_d;
      step_q  <= step_d;
    end
  end

  assign aes.s_aes_ready = (fsm_q == StIdle);
  assign aes.m_aes_block = out_q;
  assign aes.round       = round_q;
  assign aes.round_key   = key_q;

endmodule

// File: tb/tb_aes128_cipher.sv
// Bench for aes128_cipher: ENC and DEC instances in FAST, DEFAULT and TINY modes against
// the SP 800-38A ECB-AES128 vectors, plus latency, busy-start and mid-operation reset.
module tb_aes128_cipher;

  localparam int NumDut = 6;  // 0..2 ENC FAST/DEFAULT/TINY, 3..5 DEC FAST/DEFAULT/TINY
  localparam int Lat [3] = '{12, 22, 62};

  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PT [4] = '{
    128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
    128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
  localparam logic [127:0] CT [4] = '{
    128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
    128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] key_v   [NumDut];
  logic [127:0] blk_v   [NumDut];
  logic         valid_v [NumDut];
  logic         ready_v [NumDut];
  logic [127:0] out_v   [NumDut];
  logic [127:0] rk_v    [NumDut];
  logic [3:0]   rnd_v   [NumDut];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    localparam string Dir  = (g < 3) ? "ENC" : "DEC";
    localparam string Mode = (g % 3 == 0) ? "FAST" : ((g % 3 == 1) ? "DEFAULT" : "TINY");
    aes128_cipher_if bus ();
    assign bus.s_aes_key   = key_v[g];
    assign bus.s_aes_block = blk_v[g];
    assign bus.s_aes_valid = valid_v[g];
    assign ready_v[g]      = bus.s_aes_ready;
    assign out_v[g]        = bus.m_aes_block;
    assign rk_v[g]         = bus.round_key;
    assign rnd_v[g]        = bus.round;
    aes128_cipher #(.CFG_DIR(Dir), .CFG_MODE(Mode)) u_dut (
      .clk (clk),
      .rst (rst),
      .aes (bus)
    );
  end

  task automatic start_op(input int d, input logic [127:0] key, input logic [127:0] blk);
    @(negedge clk);
    key_v[d]   = key;
    blk_v[d]   = blk;
    valid_v[d] = 1'b1;
    @(posedge clk);
    #1;
    valid_v[d] = 1'b0;
  endtask

  // Counts edges after the start edge until ready; gives up at 200.
  task automatic wait_done(input int d, output int cycles);
    cycles = 0;
    while (ready_v[d] !== 1'b1 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run_op(input int d, input logic [127:0] key, input logic [127:0] blk,
                        output logic [127:0] res, output int cycles);
    start_op(d, key, blk);
    wait_done(d, cycles);
    res = out_v[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < NumDut; d++) begin
      total++;
      if (ready_v[d] !== 1'b1) begin
        bad++; $display("FAIL reset_ready dut%0d got=%b want=1", d, ready_v[d]);
      end
      total++;
      if (out_v[d] !== 128'h0) begin
        bad++; $display("FAIL reset_block dut%0d got=%h want=0", d, out_v[d]);
      end
      total++;
      if (rnd_v[d] !== 4'd0) begin
        bad++; $display("FAIL reset_round dut%0d got=%0d want=0", d, rnd_v[d]);
      end
      total++;
      if (rk_v[d] !== 128'h0) begin
        bad++; $display("FAIL reset_round_key dut%0d got=%h want=0", d, rk_v[d]);
      end
    end
  endtask

  task automatic test_enc_modes();
    logic [127:0] res;
    int           c;
    for (int d = 0; d < 3; d++) begin
      run_op(d, K0, PT[0], res, c);
      total++;
      if (res !== CT[0]) begin
        bad++; $display("FAIL enc_result dut%0d got=%h want=%h", d, res, CT[0]);
      end
      total++;
      if (c !== Lat[d]) begin
        bad++; $display("FAIL enc_latency dut%0d got=%0d want=%0d", d, c, Lat[d]);
      end
      total++;
      if (rnd_v[d] !== 4'd10) begin
        bad++; $display("FAIL enc_round dut%0d got=%0d want=10", d, rnd_v[d]);
      end
      total++;
      if (rk_v[d] !== K10) begin
        bad++; $display("FAIL enc_round_key dut%0d got=%h want=%h", d, rk_v[d], K10);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] res;
    int           c;
    for (int d = 0; d < 3; d++) begin
      for (int i = 1; i < 4; i++) begin
        run_op(d, K0, PT[i], res, c);
        total++;
        if (res !== CT[i]) begin
          bad++; $display("FAIL b2b_result dut%0d blk%0d got=%h want=%h", d, i, res, CT[i]);
        end
        total++;
        if (rk_v[d] !== K10) begin
          bad++; $display("FAIL b2b_round_key dut%0d blk%0d got=%h want=%h", d, i, rk_v[d], K10);
        end
        total++;
        if (rnd_v[d] !== 4'd10) begin
          bad++; $display("FAIL b2b_round dut%0d blk%0d got=%0d want=10", d, i, rnd_v[d]);
        end
      end
    end
  endtask

  task automatic test_dec_modes();
    logic [127:0] res;
    int           c;
    for (int d = 3; d < NumDut; d++) begin
      for (int i = 0; i < 4; i++) begin
        run_op(d, K10, CT[i], res, c);
        total++;
        if (res !== PT[i]) begin
          bad++; $display("FAIL dec_result dut%0d blk%0d got=%h want=%h", d, i, res, PT[i]);
        end
        total++;
        if (c !== Lat[d-3]) begin
          bad++; $display("FAIL dec_latency dut%0d got=%0d want=%0d", d, c, Lat[d-3]);
        end
        total++;
        if (rnd_v[d] !== 4'd0) begin
          bad++; $display("FAIL dec_round dut%0d blk%0d got=%0d want=0", d, i, rnd_v[d]);
        end
        total++;
        if (rk_v[d] !== K0) begin
          bad++; $display("FAIL dec_round_key dut%0d blk%0d got=%h want=%h", d, i, rk_v[d], K0);
        end
      end
    end
  endtask

  task automatic test_busy_valid();
    int c;
    for (int d = 0; d < 3; d++) begin
      start_op(d, K0, PT[0]);
      key_v[d]   = ~K0;
      blk_v[d]   = PT[3];
      valid_v[d] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      valid_v[d] = 1'b0;
      wait_done(d, c);
      total++;
      if (out_v[d] !== CT[0]) begin
        bad++; $display("FAIL busy_result dut%0d got=%h want=%h", d, out_v[d], CT[0]);
      end
      total++;
      if (c + 5 !== Lat[d]) begin
        bad++; $display("FAIL busy_latency dut%0d got=%0d want=%0d", d, c + 5, Lat[d]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int           c;
    start_op(1, K0, PT[1]);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (ready_v[1] !== 1'b1) begin
      bad++; $display("FAIL midrst_ready got=%b want=1", ready_v[1]);
    end
    total++;
    if (out_v[1] !== 128'h0) begin
      bad++; $display("FAIL midrst_block got=%h want=0", out_v[1]);
    end
    total++;
    if (rnd_v[1] !== 4'd0) begin
      bad++; $display("FAIL midrst_round got=%0d want=0", rnd_v[1]);
    end
    total++;
    if (rk_v[1] !== 128'h0) begin
      bad++; $display("FAIL midrst_round_key got=%h want=0", rk_v[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(1, K0, PT[2], res, c);
    total++;
    if (res !== CT[2]) begin
      bad++; $display("FAIL midrst_restart got=%h want=%h", res, CT[2]);
    end
    total++;
    if (c !== Lat[1]) begin
      bad++; $display("FAIL midrst_latency got=%0d want=%0d", c, Lat[1]);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < NumDut; d++) begin
      key_v[d]   = '0;
      blk_v[d]   = '0;
      valid_v[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_enc_modes();
    test_back_to_back();
    test_dec_modes();
    test_busy_valid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
